// File: rtl/sdram_wfifo_ctrl_if.sv
// Handshake/data bundle between the UART-side writer, the write buffer and the SDRAM write engine.
interface sdram_wfifo_ctrl_if #(
   parameter int unsigned IN_W  = 8,
   parameter int unsigned OUT_W = 16,
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic             flush;
   logic             wr_en;
   logic [IN_W-1:0]  wr_data;
   logic             rd_en;
   logic [OUT_W-1:0] rd_data;
   logic             burst_done;
   logic             wr_trig;
   logic             full;
   logic             empty;
   logic [LW-1:0]    level;
   logic             overflow;

   modport master (
      output flush, wr_en, wr_data, rd_en, burst_done,
      input  rd_data, wr_trig, full, empty, level, overflow
   );

   modport slave (
      input  flush, wr_en, wr_data, rd_en, burst_done,
      output rd_data, wr_trig, full, empty, level, overflow
   );
endinterface

// File: rtl/sdram_wfifo_ctrl.sv
// SDRAM write buffer: packs IN_W pieces into OUT_W words, FIFOs them, pulses wr_trig per buffered burst.
// Optional partial-burst idle timeout enabled by defining SDRAM_WFIFO_TIMEOUT_EN.
module sdram_wfifo_ctrl #(
   parameter int unsigned IN_W        = 8,
   parameter int unsigned OUT_W       = 16,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned BURST_LEN   = 4,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                clk,
   input  logic                rst,
   sdram_wfifo_ctrl_if.slave   bus
);
   localparam int unsigned K  = OUT_W / IN_W;
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

   if ((OUT_W % IN_W) != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
       BURST_LEN < 1 || BURST_LEN > DEPTH || TIMEOUT_CYC < 1) begin : g_param_err
      $error("sdram_wfifo_ctrl: illegal parameter combination");
   end

   typedef enum logic {IDLE, BUSY} state_t;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [OUT_W-1:0] pbuf_q, pbuf_d;
   logic [OUT_W-1:0] word;
   logic             push_req, push_ok, pop_ok;
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [LW-1:0]    level_q, level_d;
   logic             full_q, empty_q, ovf_q;
   logic [OUT_W-1:0] rd_data_q;
   logic [OUT_W-1:0] mem_q [DEPTH];
   state_t           state_q, state_d;
   logic             trig;

`ifdef SDRAM_WFIFO_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmr_q, tmr_d;
`endif

   // Packer: the incoming piece lands in slot cnt_q; the completed word is pushed in the same cycle
   always_comb begin
      word = pbuf_q;
      word[int'(cnt_q)*IN_W +: IN_W] = bus.wr_data;
      push_req = bus.wr_en && (cnt_q == CW'(K - 1));
      cnt_d    = cnt_q;
      pbuf_d   = pbuf_q;
      if (bus.wr_en) begin
         if (push_req) begin
            cnt_d  = '0;
            pbuf_d = '0;
         end else begin
            cnt_d  = cnt_q + CW'(1);
            pbuf_d = word;
         end
      end
   end

   assign pop_ok  = bus.rd_en && !empty_q && !bus.flush;
   assign push_ok = push_req && !bus.flush && (!full_q || pop_ok);
   assign level_d = level_q + LW'(push_ok) - LW'(pop_ok);

   always_comb begin
      state_d = state_q;
      trig    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!bus.flush && level_q >= LW'(BURST_LEN)) begin
               trig    = 1'b1;
               state_d = BUSY;
            end
`ifdef SDRAM_WFIFO_TIMEOUT_EN
            else if (!bus.flush && level_q != '0 && tmr_q >= TW'(TIMEOUT_CYC)) begin
               trig    = 1'b1;
               state_d = BUSY;
            end
`endif
         end
         BUSY: if (bus.burst_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.flush) state_d = IDLE;
   end

`ifdef SDRAM_WFIFO_TIMEOUT_EN
   // Saturating count of cycles since the last accepted push
   always_comb begin
      tmr_d = tmr_q;
      if (push_ok || trig || bus.flush) tmr_d = '0;
      else if (tmr_q < TW'(TIMEOUT_CYC)) tmr_d = tmr_q + TW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmr_q <= '0;
      else     tmr_q <= tmr_d;
   end
`endif

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= word;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         pbuf_q    <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         level_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         ovf_q     <= 1'b0;
         rd_data_q <= '0;
         state_q   <= IDLE;
      end else if (bus.flush) begin
         cnt_q   <= '0;
         pbuf_q  <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
         state_q <= IDLE;
      end else begin
         cnt_q   <= cnt_d;
         pbuf_q  <= pbuf_d;
         state_q <= state_d;
         level_q <= level_d;
         full_q  <= (level_d == LW'(DEPTH));
         empty_q <= (level_d == '0);
         if (push_ok) wptr_q <= wptr_q + AW'(1);
         if (pop_ok) begin
            rptr_q    <= rptr_q + AW'(1);
            rd_data_q <= mem_q[rptr_q];
         end
         if (push_req && !push_ok) ovf_q <= 1'b1;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.wr_trig  = trig;
   assign bus.full     = full_q;
   assign bus.empty    = empty_q;
   assign bus.level    = level_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_sdram_wfifo_ctrl.sv
// Scoreboard bench for sdram_wfifo_ctrl: queue-based reference model, directed scenarios then random traffic.
module tb_sdram_wfifo_ctrl;
   localparam int unsigned IN_W      = 8;
   localparam int unsigned OUT_W     = 16;
   localparam int unsigned DEPTH     = 16;
   localparam int unsigned BURST_LEN = 4;
   localparam int unsigned K         = OUT_W / IN_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sdram_wfifo_ctrl_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

   sdram_wfifo_ctrl #(
      .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH),
      .BURST_LEN(BURST_LEN), .TIMEOUT_CYC(1024)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int unsigned      level;
      logic             full;
      logic             empty;
      logic             ovf;
      logic             trig;
      logic [OUT_W-1:0] rd;
   } exp_t;

   exp_t             exp_q[$];
   logic [OUT_W-1:0] m_fifo[$];
   logic [IN_W-1:0]  m_pend[$];
   bit               m_ovf;
   bit               m_busy;
   logic [OUT_W-1:0] m_rd;
   int               n_checks = 0;
   int               n_pass   = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
   endfunction

   task automatic drive_idle();
      bus.flush = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0;
      bus.rd_en = 1'b0; bus.burst_done = 1'b0;
   endtask

   // One clock of stimulus; queues what the DUT must show during this cycle, then advances the model
   task automatic cycle(input bit fl, input bit we, input logic [IN_W-1:0] d,
                        input bit re, input bit bd);
      exp_t             e;
      bit               pop;
      logic [OUT_W-1:0] w;
      @(posedge clk); #2;
      bus.flush = fl; bus.wr_en = we; bus.wr_data = d;
      bus.rd_en = re; bus.burst_done = bd;
      e.level = m_fifo.size();
      e.full  = (m_fifo.size() == DEPTH);
      e.empty = (m_fifo.size() == 0);
      e.ovf   = m_ovf;
      e.rd    = m_rd;
      e.trig  = !m_busy && !fl && (m_fifo.size() >= BURST_LEN);
      exp_q.push_back(e);
      if (fl) begin
         m_fifo.delete(); m_pend.delete(); m_ovf = 0; m_busy = 0;
      end else begin
         if (e.trig) m_busy = 1;
         else if (m_busy && bd) m_busy = 0;
         pop = re && (m_fifo.size() != 0);
         if (pop) m_rd = m_fifo.pop_front();
         if (we) m_pend.push_back(d);
         if (m_pend.size() == K) begin
            w = '0;
            for (int i = 0; i < K; i++) w |= OUT_W'(m_pend[i]) << (i * IN_W);
            m_pend.delete();
            if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
            else m_ovf = 1;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      rst = 1'b1;
      drive_idle();
      #1;
      check("reset_level", bus.level, 0);
      check("reset_empty", bus.empty, 1);
      check("reset_full", bus.full, 0);
      check("reset_overflow", bus.overflow, 0);
      check("reset_wr_trig", bus.wr_trig, 0);
      check("reset_rd_data", bus.rd_data, 0);
      m_fifo.delete(); m_pend.delete(); m_ovf = 0; m_busy = 0; m_rd = '0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("level", bus.level, e.level);
            check("full", bus.full, e.full);
            check("empty", bus.empty, e.empty);
            check("overflow", bus.overflow, e.ovf);
            check("wr_trig", bus.wr_trig, e.trig);
            check("rd_data", bus.rd_data, e.rd);
         end
      end
   end

   initial begin : driver
      drive_idle();
      do_reset();
      // Eight bytes -> four words, one trigger, four ordered pops
      for (int i = 1; i <= 8; i++) cycle(0, 1, IN_W'(i), 0, 0);
      repeat (2) cycle(0, 0, 0, 0, 0);
      repeat (4) cycle(0, 0, 0, 1, 0);
      repeat (2) cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      // Fill to DEPTH while the burst is held busy, then overflow
      for (int i = 0; i < 2 * DEPTH; i++) cycle(0, 1, IN_W'($urandom), 0, 0);
      cycle(0, 1, 8'h5A, 0, 0);
      cycle(0, 1, 8'hA5, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 1, 8'hAA, 0, 0);
      cycle(0, 1, 8'hBB, 1, 0);
      repeat (3) cycle(0, 0, 0, 0, 0);
      // Release the burst at a high level: retrigger expected
      cycle(0, 0, 0, 0, 1);
      repeat (3) cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      repeat (DEPTH + 1) cycle(0, 0, 0, 1, 0);
      // Pops on empty change nothing
      repeat (3) cycle(0, 0, 0, 1, 0);
      // Push+pop with one word stored
      cycle(0, 1, 8'h10, 0, 0);
      cycle(0, 1, 8'h20, 0, 0);
      cycle(0, 1, 8'h30, 0, 0);
      cycle(0, 1, 8'h40, 1, 0);
      repeat (2) cycle(0, 0, 0, 1, 0);
      // Flush with a piece pending and wr_en high; next two bytes form a fresh word
      cycle(0, 1, 8'h11, 0, 0);
      cycle(0, 1, 8'h22, 0, 0);
      cycle(0, 1, 8'h33, 0, 0);
      cycle(1, 1, 8'h44, 1, 0);
      cycle(0, 1, 8'h55, 0, 0);
      cycle(0, 1, 8'h66, 0, 0);
      cycle(0, 0, 0, 1, 0);
      repeat (2) cycle(0, 0, 0, 0, 0);
      // Asynchronous reset in the middle of a burst with a piece pending
      for (int i = 0; i < 9; i++) cycle(0, 1, IN_W'($urandom), 0, 0);
      do_reset();
      repeat (2) cycle(0, 0, 0, 0, 0);
      // Random traffic
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 149) == 0, $urandom_range(0, 99) < 55, IN_W'($urandom),
               $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15);
      repeat (3) cycle(0, 0, 0, 0, 0);
      @(negedge clk); #1;
      if (exp_q.size() != 0) check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
